sample_msg_combiner: RTL and testbench

Merges a raw sample stream and a message stream into one tagged `WDTH`-bit stream, in exactly the format `sample_msg_splitter` separates.
- Sits at the transmit end of a link; the splitter sits at the receive end.
- Buffers both inputs.
- Schedules each whole message as a contiguous header-plus-body burst into gaps in the sample stream.
- Flags any overflow or framing violation on `error`.

---
 rtl/sample_msg_combiner_pkg.sv | 18 +
 rtl/sample_msg_combiner_if.sv | 28 ++
 rtl/sample_msg_combiner_fifo.sv | 62 ++++++
 rtl/sample_msg_combiner.sv | 156 +++++++++++++++
 tb/tb_sample_msg_combiner.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sample_msg_combiner_pkg.sv
// Shared constants and types for the sample/message combiner.
// The message widths must agree with the matching splitter at the receive end.
package sample_msg_combiner_pkg;

  localparam int MSG_WIDTH        = 16;
  localparam int MSG_LENGTH_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_BODY   = 2'd2
  } schedState_e;

  function automatic int hdr_flag_pos(input int wdth);
    return wdth - 1;
  endfunction

endpackage

// File: rtl/sample_msg_combiner_if.sv
// Input streams and tagged output of the combiner.
// The master drives the inputs and the slave drives the outputs.
interface sample_msg_combiner_if
  import sample_msg_combiner_pkg::*;
#(
  parameter int WDTH = 32
);

  logic [WDTH-1:0]      in_samples;
  logic                 in_samples_nd;
  logic [MSG_WIDTH-1:0] in_msg;
  logic                 in_msg_nd;
  logic                 in_msg_last;
  logic [WDTH-1:0]      out_data;
  logic                 out_nd;
  logic                 error;

  modport master (
    output in_samples, in_samples_nd, in_msg, in_msg_nd, in_msg_last,
    input  out_data, out_nd, error
  );

  modport slave (
    input  in_samples, in_samples_nd, in_msg, in_msg_nd, in_msg_last,
    output out_data, out_nd, error
  );

endinterface

// File: rtl/sample_msg_combiner_fifo.sv
// Synchronous FIFO whose write side can be committed or rolled back.
// Readers only see committed words; rollback rewinds the write pointer.
module smc_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrEn_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             commit_i,
  input  logic             rollback_i,
  input  logic             rdEn_i,
  output logic [WIDTH-1:0] rdData_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] PTR_ONE  = {{DEPTH_LOG{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG:0] FULL_XOR = {1'b1, {DEPTH_LOG{1'b0}}};

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG:0] wrPtr_q, wrPtr_d;
  logic [DEPTH_LOG:0] cmPtr_q, cmPtr_d;
  logic [DEPTH_LOG:0] rdPtr_q, rdPtr_d;
  logic               doWr, doRd;

  assign full_o   = (wrPtr_q ^ rdPtr_q) == FULL_XOR;
  assign empty_o  = (cmPtr_q == rdPtr_q);
  assign doRd     = rdEn_i && !empty_o;
  assign doWr     = wrEn_i && !rollback_i && (!full_o || doRd);
  assign rdData_o = mem_q[rdPtr_q[DEPTH_LOG-1:0]];

  // A read in the same cycle frees its slot, so a full FIFO may still accept a write.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    cmPtr_d = cmPtr_q;
    if (doRd) rdPtr_d = rdPtr_q + PTR_ONE;
    if (rollback_i) wrPtr_d = cmPtr_q;
    else if (doWr) wrPtr_d = wrPtr_q + PTR_ONE;
    if (commit_i && !rollback_i) cmPtr_d = wrPtr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      cmPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      cmPtr_q <= cmPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doWr) mem_q[wrPtr_q[DEPTH_LOG-1:0]] <= wrData_i;
  end

endmodule

// File: rtl/sample_msg_combiner.sv
// Merges a raw sample stream and a message stream into one tagged stream.
// Whole messages are sent as header-plus-body bursts in gaps between samples.
module sample_msg_combiner
  import sample_msg_combiner_pkg::*;
#(
  parameter int WDTH     = 32,
  parameter int SBUF_LOG = 4,
  parameter int MBUF_LOG = 5,
  parameter int NMSG_LOG = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  sample_msg_combiner_if.slave bus
);

  localparam int FLAG = hdr_flag_pos(WDTH);
  localparam logic [MSG_LENGTH_WIDTH-1:0] LEN_ONE = MSG_LENGTH_WIDTH'(1);
  localparam logic [MSG_LENGTH_WIDTH-1:0] LEN_MAX = '1;

  logic [WDTH-1:0]             sRdata;
  logic                        sWr, sRd, sEmpty, sFull, sBad, sOvf;
  logic [MSG_WIDTH-1:0]        mRdata;
  logic                        mWr, mRd, mEmpty, mFull, mCommit, mRollback;
  logic [MSG_LENGTH_WIDTH-1:0] lWdata, lRdata;
  logic                        lWr, lRd, lEmpty, lFull;
  logic                        msgErr, free;

  logic [MSG_LENGTH_WIDTH-1:0] lenCnt_q, lenCnt_d;
  logic                        drop_q, drop_d;
  schedState_e                 state_q, state_d;
  logic [MSG_LENGTH_WIDTH-1:0] rem_q, rem_d;
  logic [WDTH-1:0]             outData_q, outData_d;
  logic                        outNd_q, outNd_d;
  logic                        error_q, error_d;

  smc_fifo #(.WIDTH(WDTH), .DEPTH_LOG(SBUF_LOG)) u_sfifo (
    .clk(clk), .rst_n(rst_n),
    .wrEn_i(sWr), .wrData_i(bus.in_samples),
    .commit_i(1'b1), .rollback_i(1'b0),
    .rdEn_i(sRd), .rdData_o(sRdata),
    .empty_o(sEmpty), .full_o(sFull)
  );

  smc_fifo #(.WIDTH(MSG_WIDTH), .DEPTH_LOG(MBUF_LOG)) u_mfifo (
    .clk(clk), .rst_n(rst_n),
    .wrEn_i(mWr), .wrData_i(bus.in_msg),
    .commit_i(mCommit), .rollback_i(mRollback),
    .rdEn_i(mRd), .rdData_o(mRdata),
    .empty_o(mEmpty), .full_o(mFull)
  );

  smc_fifo #(.WIDTH(MSG_LENGTH_WIDTH), .DEPTH_LOG(NMSG_LOG)) u_lfifo (
    .clk(clk), .rst_n(rst_n),
    .wrEn_i(lWr), .wrData_i(lWdata),
    .commit_i(1'b1), .rollback_i(1'b0),
    .rdEn_i(lRd), .rdData_o(lRdata),
    .empty_o(lEmpty), .full_o(lFull)
  );

  assign sBad   = bus.in_samples_nd && bus.in_samples[FLAG];
  assign sWr    = bus.in_samples_nd && !bus.in_samples[FLAG];
  assign sOvf   = sWr && sFull && !sRd;
  assign lWdata = lenCnt_q + LEN_ONE;

  // Any failure mid-message rewinds to the message start and ignores words up to its last.
  always_comb begin
    mWr       = 1'b0;
    mCommit   = 1'b0;
    mRollback = 1'b0;
    lWr       = 1'b0;
    msgErr    = 1'b0;
    lenCnt_d  = lenCnt_q;
    drop_d    = drop_q;
    if (bus.in_msg_nd) begin
      if (drop_q) begin
        if (bus.in_msg_last) drop_d = 1'b0;
      end else if ((mFull && !mRd) || (lenCnt_q == LEN_MAX)) begin
        mRollback = 1'b1;
        msgErr    = 1'b1;
        lenCnt_d  = '0;
        drop_d    = !bus.in_msg_last;
      end else if (bus.in_msg_last && lFull && !lRd) begin
        mRollback = 1'b1;
        msgErr    = 1'b1;
        lenCnt_d  = '0;
      end else begin
        mWr      = 1'b1;
        lenCnt_d = lenCnt_q + LEN_ONE;
        if (bus.in_msg_last) begin
          mCommit  = 1'b1;
          lWr      = 1'b1;
          lenCnt_d = '0;
        end
      end
    end
  end

  // State names the word being registered; a drained BODY may choose the next word at once.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    sRd       = 1'b0;
    mRd       = 1'b0;
    lRd       = 1'b0;
    outNd_d   = 1'b0;
    outData_d = '0;
    free      = (state_q == ST_IDLE) || ((state_q == ST_BODY) && (rem_q == '0));
    if (free) begin
      state_d = ST_IDLE;
      if (!sEmpty) begin
        sRd       = 1'b1;
        outNd_d   = 1'b1;
        outData_d = sRdata;
      end else if (!lEmpty) begin
        outNd_d                             = 1'b1;
        outData_d[FLAG]                     = 1'b1;
        outData_d[MSG_LENGTH_WIDTH-1:0]     = lRdata;
        rem_d                               = lRdata;
        state_d                             = ST_HEADER;
      end
    end else if (!mEmpty) begin
      mRd                      = 1'b1;
      outNd_d                  = 1'b1;
      outData_d[MSG_WIDTH-1:0] = mRdata;
      rem_d                    = rem_q - LEN_ONE;
      lRd                      = (rem_q == LEN_ONE);
      state_d                  = ST_BODY;
    end
    error_d = sBad || sOvf || msgErr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lenCnt_q  <= '0;
      drop_q    <= 1'b0;
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      outData_q <= '0;
      outNd_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      lenCnt_q  <= lenCnt_d;
      drop_q    <= drop_d;
      state_q   <= state_d;
      rem_q     <= rem_d;
      outData_q <= outData_d;
      outNd_q   <= outNd_d;
      error_q   <= error_d;
    end
  end

  assign bus.out_data = outData_q;
  assign bus.out_nd   = outNd_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_sample_msg_combiner.sv
// Directed bench for sample_msg_combiner with hand-computed expected streams.
// Outputs are sampled 1ns after each rising edge.
module tb_sample_msg_combiner;

  localparam int WDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_msg_combiner_if #(.WDTH(WDTH)) bus ();

  sample_msg_combiner #(.WDTH(WDTH), .SBUF_LOG(4), .MBUF_LOG(5), .NMSG_LOG(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int errPulses = 0;
  int errBase = 0;
  logic [WDTH-1:0] outQ[$];
  logic [WDTH-1:0] exp4[33];

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.out_nd) outQ.push_back(bus.out_data);
    if (bus.error) errPulses++;
  endtask

  task automatic applyStimulus(input logic sNd, input logic [WDTH-1:0] s,
                               input logic mNd, input logic [15:0] m, input logic last);
    bus.in_samples_nd = sNd;
    bus.in_samples    = s;
    bus.in_msg_nd     = mNd;
    bus.in_msg        = m;
    bus.in_msg_last   = last;
  endtask

  task automatic checkOutput(input string tag, input logic [WDTH-1:0] observed,
                             input logic [WDTH-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, '0, 0, '0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_data", bus.out_data, 32'h0);
    checkOutput("reset out_nd", WDTH'(bus.out_nd), 32'h0);
    checkOutput("reset error", WDTH'(bus.error), 32'h0);
    rst_n = 1'b1;
    tick();

    // Three back-to-back samples, each two cycles after its input
    outQ.delete(); errBase = errPulses;
    applyStimulus(1, 32'h11, 0, '0, 0); tick();
    checkOutput("t1 nd before", WDTH'(bus.out_nd), 32'h0);
    applyStimulus(1, 32'h22, 0, '0, 0); tick();
    checkOutput("t1 s0", bus.out_data, 32'h11);
    checkOutput("t1 nd0", WDTH'(bus.out_nd), 32'h1);
    applyStimulus(1, 32'h33, 0, '0, 0); tick();
    checkOutput("t1 s1", bus.out_data, 32'h22);
    applyStimulus(0, '0, 0, '0, 0); tick();
    checkOutput("t1 s2", bus.out_data, 32'h33);
    tick();
    checkOutput("t1 nd after", WDTH'(bus.out_nd), 32'h0);
    checkOutput("t1 errors", WDTH'(errPulses - errBase), 32'h0);

    // Three-word message with no samples pending
    applyStimulus(0, '0, 1, 16'hA, 0); tick();
    applyStimulus(0, '0, 1, 16'hB, 0); tick();
    applyStimulus(0, '0, 1, 16'hC, 1); tick();
    applyStimulus(0, '0, 0, '0, 0); tick();
    checkOutput("t2 header", bus.out_data, 32'h8000_0003);
    tick(); checkOutput("t2 body0", bus.out_data, 32'h0000_000A);
    tick(); checkOutput("t2 body1", bus.out_data, 32'h0000_000B);
    tick(); checkOutput("t2 body2", bus.out_data, 32'h0000_000C);
    checkOutput("t2 body2 nd", WDTH'(bus.out_nd), 32'h1);
    tick(); checkOutput("t2 nd after", WDTH'(bus.out_nd), 32'h0);

    // Samples arriving during BODY wait until the message ends
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 1, 16'h101 + 16'(i), (i == 3)); tick();
    end
    applyStimulus(0, '0, 0, '0, 0); tick();
    checkOutput("t3 header", bus.out_data, 32'h8000_0004);
    applyStimulus(1, 32'h5, 0, '0, 0); tick();
    checkOutput("t3 body0", bus.out_data, 32'h101);
    applyStimulus(1, 32'h6, 0, '0, 0); tick();
    checkOutput("t3 body1", bus.out_data, 32'h102);
    applyStimulus(0, '0, 0, '0, 0); tick();
    checkOutput("t3 body2", bus.out_data, 32'h103);
    tick(); checkOutput("t3 body3", bus.out_data, 32'h104);
    tick(); checkOutput("t3 sample5", bus.out_data, 32'h5);
    tick(); checkOutput("t3 sample6", bus.out_data, 32'h6);
    tick(); checkOutput("t3 nd after", WDTH'(bus.out_nd), 32'h0);

    // 17 samples while a 16-word body is streaming: the last one overflows
    outQ.delete(); errBase = errPulses;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, '0, 1, 16'h400 + 16'(i), (i == 15)); tick();
    end
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 32'h200 + 32'(i), 0, '0, 0); tick();
      if (i == 16) checkOutput("t4 error on 17th", WDTH'(bus.error), 32'h1);
    end
    applyStimulus(0, '0, 0, '0, 0);
    repeat (25) tick();
    exp4[0] = 32'h8000_0010;
    for (int i = 0; i < 16; i++) begin
      exp4[1 + i]  = 32'h400 + 32'(i);
      exp4[17 + i] = 32'h200 + 32'(i);
    end
    checkOutput("t4 word count", WDTH'(outQ.size()), 32'd33);
    for (int i = 0; i < 33; i++) begin
      checkOutput($sformatf("t4 word%0d", i), (i < outQ.size()) ? outQ[i] : 'x, exp4[i]);
    end
    checkOutput("t4 errors", WDTH'(errPulses - errBase), 32'h1);

    // A sample with the flag bit set is dropped
    outQ.delete(); errBase = errPulses;
    applyStimulus(1, 32'h8000_0001, 0, '0, 0); tick();
    checkOutput("t5 bad sample error", WDTH'(bus.error), 32'h1);
    applyStimulus(0, '0, 0, '0, 0);
    repeat (4) tick();
    checkOutput("t5 bad sample dropped", WDTH'(outQ.size()), 32'h0);
    checkOutput("t5 bad sample errors", WDTH'(errPulses - errBase), 32'h1);

    // 33-word message overflows the 32-word buffer; a following message survives
    outQ.delete(); errBase = errPulses;
    for (int i = 0; i < 33; i++) begin
      applyStimulus(0, '0, 1, 16'h300 + 16'(i), (i == 32)); tick();
      if (i == 31) checkOutput("t6 no error at 32", WDTH'(bus.error), 32'h0);
    end
    checkOutput("t6 error at 33", WDTH'(bus.error), 32'h1);
    applyStimulus(0, '0, 0, '0, 0);
    repeat (4) tick();
    checkOutput("t6 nothing emitted", WDTH'(outQ.size()), 32'h0);
    applyStimulus(0, '0, 1, 16'h51, 0); tick();
    applyStimulus(0, '0, 1, 16'h52, 1); tick();
    applyStimulus(0, '0, 0, '0, 0);
    repeat (6) tick();
    checkOutput("t6 count", WDTH'(outQ.size()), 32'd3);
    checkOutput("t6 header", (outQ.size() > 0) ? outQ[0] : 'x, 32'h8000_0002);
    checkOutput("t6 body0", (outQ.size() > 1) ? outQ[1] : 'x, 32'h51);
    checkOutput("t6 body1", (outQ.size() > 2) ? outQ[2] : 'x, 32'h52);
    checkOutput("t6 errors", WDTH'(errPulses - errBase), 32'h1);

    // Reset during BODY clears outputs at once and discards all buffered data
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, '0, 1, 16'h601 + 16'(i), (i == 3)); tick();
    end
    applyStimulus(0, '0, 0, '0, 0); tick();
    checkOutput("t7 header", bus.out_data, 32'h8000_0004);
    applyStimulus(1, 32'h99, 0, '0, 0); tick();
    checkOutput("t7 body0", bus.out_data, 32'h601);
    applyStimulus(0, '0, 0, '0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t7 reset out_nd", WDTH'(bus.out_nd), 32'h0);
    checkOutput("t7 reset out_data", bus.out_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    outQ.delete(); errBase = errPulses;
    tick();
    applyStimulus(1, 32'h77, 0, '0, 0); tick();
    applyStimulus(0, '0, 0, '0, 0); tick();
    checkOutput("t7 fresh sample", bus.out_data, 32'h77);
    repeat (8) tick();
    checkOutput("t7 no leftovers", WDTH'(outQ.size()), 32'h1);
    checkOutput("t7 errors", WDTH'(errPulses - errBase), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
